// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB4 bus bundle between an interconnect port and the register-file slave
// Signals: paddr/pprot/psel/penable/pwrite/pwdata/pstrb driven by the master;
// pready/prdata/pslverr driven by the slave.
interface apb_regfile_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0] pprot;
  logic psel;
  logic penable;
  logic pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic pslverr;
  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input pready, prdata, pslverr
  );
  modport slave (
    input paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: parametrised APB4 register file with wait states, byte strobes, RO mapping and privilege check
// Ports: pclk clock; presetn synchronous active-low reset; bus APB4 slave modport;
// reg_q RW register contents (RO slices read as 0); reg_wr one-cycle write pulses;
// hw_rdata values returned for read-only registers.
module apb_regfile_slave #(
  parameter int unsigned BASE_ADDR = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned N_REGS = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  parameter bit PRIV_ONLY = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input logic pclk,
  input logic presetn,
  apb_regfile_slave_if.slave bus,
  output logic [N_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [N_REGS-1:0] reg_wr,
  input logic [N_REGS*DATA_WIDTH-1:0] hw_rdata
);
  localparam int unsigned STRB = DATA_WIDTH / 8;
  localparam int unsigned IW = N_REGS > 1 ? $clog2(N_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M = ADDR_WIDTH'(STRB - 1);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(BASE_ADDR + N_REGS * STRB);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [3:0] cnt;
  logic wr_q, err_q, done, ro, err, unused;
  logic [IW-1:0] idx, idx_q;
  logic [ADDR_WIDTH-1:0] off;
  logic [DATA_WIDTH-1:0] rd, rdata_q;
  logic [DATA_WIDTH-1:0] regs [N_REGS];
  assign unused = ^bus.pprot[2:1];
  // Decode is only sampled on the setup cycle; everything the bus sees later comes from flops.
  always_comb begin
    off = bus.paddr - BASE;
    idx = IW'(off >> $clog2(STRB));
    ro = RO_MASK[idx];
    err = bus.paddr < BASE || {1'b0, bus.paddr} >= LIMIT || (bus.paddr & ALIGN_M) != '0 ||
          (bus.pwrite && ro) || (PRIV_ONLY && !bus.pprot[0]);
    rd = ro ? hw_rdata[idx*DATA_WIDTH +: DATA_WIDTH] : regs[idx];
  end
  always_ff @(posedge pclk) begin
    reg_wr <= '0;
    if (!presetn) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < N_REGS; i++) regs[i] <= RESET_VAL;
    end else if (state == IDLE) begin
      if (bus.psel && !bus.penable) begin
        state <= ACCESS;
        cnt <= 4'(WAIT_STATES);
        wr_q <= bus.pwrite;
        err_q <= err;
        idx_q <= idx;
        rdata_q <= err ? '0 : rd;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end else begin
      state <= IDLE;
      if (wr_q && !err_q) begin
        reg_wr[idx_q] <= 1'b1;
        for (int b = 0; b < STRB; b++) if (bus.pstrb[b]) regs[idx_q][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
      end
    end
  end
  assign done = state == ACCESS && cnt == '0;
  assign bus.pready = done;
  assign bus.pslverr = done && err_q;
  assign bus.prdata = done && !err_q ? rdata_q : '0;
  for (genvar i = 0; i < N_REGS; i++) begin : g_q
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
  end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: scoreboard bench for two slave configurations (2 wait states, and privileged-only with 5)
module tb_apb_regfile_slave;
  typedef struct packed {logic err; logic chk; logic [31:0] data;} exp_t;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic [255:0] q0, q1, hw0, hw1;
  logic [7:0] w0, w1;
  int total = 0, bad = 0, errs0 = 0, wr_cnt0 = 0;
  exp_t q0e[$], q1e[$];
  always #5 pclk = ~pclk;
  apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  apb_regfile_slave #(.WAIT_STATES(2), .RO_MASK(8'h80)) d0 (
    .pclk(pclk), .presetn(presetn), .bus(b0), .reg_q(q0), .reg_wr(w0), .hw_rdata(hw0)
  );
  apb_regfile_slave #(.WAIT_STATES(5), .RO_MASK(8'h80), .PRIV_ONLY(1'b1)) d1 (
    .pclk(pclk), .presetn(presetn), .bus(b1), .reg_q(q1), .reg_wr(w1), .hw_rdata(hw1)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  // Monitor: every pready cycle consumes one scoreboard entry; all other cycles must be quiet.
  task automatic mon(input int w, input logic rdy, input logic err, input logic [31:0] dat);
    exp_t e;
    if (!rdy) begin
      check($sformatf("idle_pslverr%0d", w), {31'd0, err}, 32'd0);
      check($sformatf("idle_prdata%0d", w), dat, 32'd0);
      return;
    end
    if ((w == 0 && q0e.size() == 0) || (w == 1 && q1e.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL resp%0d: unexpected pready, pslverr=%b prdata=%h", w, err, dat);
      return;
    end
    if (w == 0) e = q0e.pop_front();
    else e = q1e.pop_front();
    check($sformatf("pslverr%0d", w), {31'd0, err}, {31'd0, e.err});
    if (e.chk) check($sformatf("prdata%0d", w), dat, e.data);
    if (w == 0 && err) errs0++;
  endtask
  always @(negedge pclk) if (presetn) begin
    mon(0, b0.pready, b0.pslverr, b0.prdata);
    mon(1, b1.pready, b1.pslverr, b1.prdata);
    if (w0 != 8'd0) wr_cnt0++;
  end
  task automatic drive(input int w, input logic sel, input logic en, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    if (w == 0) begin
      b0.psel = sel; b0.penable = en; b0.pwrite = wr; b0.paddr = a; b0.pwdata = d; b0.pstrb = s; b0.pprot = p;
    end else begin
      b1.psel = sel; b1.penable = en; b1.pwrite = wr; b1.paddr = a; b1.pwdata = d; b1.pstrb = s; b1.pprot = p;
    end
  endtask
  task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, input logic err, input logic chk, input logic [31:0] ed);
    int n = 0;
    logic rdy;
    exp_t e;
    e = {err, chk, ed};
    if (w == 0) q0e.push_back(e);
    else q1e.push_back(e);
    drive(w, 1'b1, 1'b0, wr, a, d, s, p);
    @(posedge pclk); #1;
    drive(w, 1'b1, 1'b1, wr, a, d, s, p);
    do begin
      @(negedge pclk);
      n++;
      rdy = w == 0 ? b0.pready : b1.pready;
    end while (!rdy && n < 30);
    check($sformatf("latency%0d@%h", w, a), n, w == 0 ? 32'd3 : 32'd6);
    @(posedge pclk); #1;
    drive(w, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] bad_addr [3] = '{32'h07, 32'h28, 32'h09};
    logic [255:0] snap;
    int e0, c0;
    hw0 = '0;
    hw0[255:224] = 32'hDEADBEEF;
    hw1 = '0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk); #1;
      b0.psel = i[0];
      b1.psel = ~i[0];
    end
    check("rst_pready", {31'd0, b0.pready}, 32'd0);
    check("rst_pslverr", {31'd0, b0.pslverr}, 32'd0);
    check("rst_prdata", b0.prdata, 32'd0);
    check("rst_reg_q", {31'd0, q0 != '0}, 32'd0);
    check("rst_reg_wr", {24'd0, w0}, 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(0, 1'b1, 32'h08, 32'hA5A50001, 4'hF, 3'd0, 1'b0, 1'b0, 32'd0);
    check("wr_pulse", {24'd0, w0}, 32'h01);
    check("reg0", q0[31:0], 32'hA5A50001);
    @(posedge pclk); #1;
    check("wr_pulse_end", {24'd0, w0}, 32'd0);
    xfer(0, 1'b0, 32'h08, 32'd0, 4'd0, 3'd0, 1'b0, 1'b1, 32'hA5A50001);
    xfer(0, 1'b1, 32'h0C, 32'd0, 4'hF, 3'd0, 1'b0, 1'b0, 32'd0);
    xfer(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0010, 3'd0, 1'b0, 1'b0, 32'd0);
    xfer(0, 1'b0, 32'h0C, 32'd0, 4'd0, 3'd0, 1'b0, 1'b1, 32'h0000FF00);
    check("reg1", q0[63:32], 32'h0000FF00);
    snap = q0;
    e0 = errs0;
    c0 = wr_cnt0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2; k++)
        xfer(0, k[0], bad_addr[i], 32'hFFFFFFFF, 4'hF, 3'd0, 1'b1, 1'b1, 32'd0);
    repeat (2) @(posedge pclk);
    #1;
    check("err_count", errs0 - e0, 32'd6);
    check("err_reg_q", {31'd0, q0 != snap}, 32'd0);
    check("err_wr_pulses", wr_cnt0 - c0, 32'd0);
    xfer(0, 1'b0, 32'h24, 32'd0, 4'd0, 3'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    c0 = wr_cnt0;
    xfer(0, 1'b1, 32'h24, 32'h12345678, 4'hF, 3'd0, 1'b1, 1'b1, 32'd0);
    repeat (2) @(posedge pclk);
    #1;
    check("ro_wr_pulses", wr_cnt0 - c0, 32'd0);
    check("ro_reg_q", q0[255:224], 32'd0);
    xfer(1, 1'b0, 32'h08, 32'd0, 4'd0, 3'b000, 1'b1, 1'b1, 32'd0);
    xfer(1, 1'b0, 32'h08, 32'd0, 4'd0, 3'b001, 1'b0, 1'b1, 32'd0);
    xfer(1, 1'b1, 32'h0C, 32'h0BADF00D, 4'hF, 3'b001, 1'b0, 1'b0, 32'd0);
    xfer(1, 1'b0, 32'h0C, 32'd0, 4'd0, 3'b001, 1'b0, 1'b1, 32'h0BADF00D);
    xfer(1, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b1, 1'b1, 32'd0);
    check("priv_reg0", q1[31:0], 32'd0);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 3'b001);
    @(posedge pclk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 3'b001);
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b0;
    @(posedge pclk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    check("abort_reg0", q1[31:0], 32'd0);
    check("abort_reg_wr", {24'd0, w1}, 32'd0);
    xfer(1, 1'b1, 32'h10, 32'h12345678, 4'hF, 3'b001, 1'b0, 1'b0, 32'd0);
    check("post_abort_pulse", {24'd0, w1}, 32'h04);
    check("post_abort_reg2", q1[95:64], 32'h12345678);
    check("post_abort_reg0", q1[31:0], 32'd0);
    repeat (3) @(posedge pclk);
    #1;
    check("queue0_drained", q0e.size(), 32'd0);
    check("queue1_drained", q1e.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
